// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, drives the combinational instruction memory and
// queues fetched {pc, instr} pairs in a small in-order buffer that decode drains.
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [63:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        imem_inv,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        fault,
   output logic [63:0] fault_pc,
   output logic [1:0]  state
);

   // DEPTH is a power of two, so the pointers wrap for free.
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_FAULT = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [63:0]      pc_q, pc_d;
   logic             fault_q, fault_d;
   logic [63:0]      fault_pc_q, fault_pc_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [63:0]      buf_pc_q    [DEPTH];
   logic [31:0]      buf_instr_q [DEPTH];

   logic             full;
   logic             pop;
   logic             fire;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign fire      = (state_q == ST_RUN) && !redirect_valid && !imem_inv && (!full || pop);

   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no path through the block leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;

      if (redirect_valid) begin
         pc_d    = redirect_pc;
         fault_d = 1'b0;
         state_d = ST_RUN;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (imem_inv) begin
                  fault_d    = 1'b1;
                  fault_pc_d = pc_q;
                  state_d    = ST_FAULT;
               end else if (fire) begin
                  pc_d = pc_q + 64'd4;
               end
            end
            ST_FAULT: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A redirect flushes the buffer outright; a same-cycle pop is simply absorbed.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (redirect_valid) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop)  head_d = head_q + PTR_W'(1);
         if (fire) tail_d = tail_q + PTR_W'(1);
         count_d = count_q + CNT_W'(fire) - CNT_W'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // NOTE: buffer storage is deliberately not reset; count_q alone decides
   // validity and the outputs below are forced to zero while it is empty.
   always_ff @(posedge clk) begin
      if (fire) begin
         buf_pc_q[tail_q]    <= pc_q;
         buf_instr_q[tail_q] <= imem_instr;
      end
   end

   assign imem_pc   = pc_q;
   assign out_pc    = out_valid ? buf_pc_q[head_q]    : '0;
   assign out_instr = out_valid ? buf_instr_q[head_q] : '0;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;
   assign state     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the fetch rules.
module tb_fetch_sequencer;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        reset, start, imem_inv, redirect_valid, out_valid, out_ready, fault;
   logic [63:0] imem_pc, redirect_pc, out_pc, fault_pc;
   logic [31:0] imem_instr, out_instr;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_pc(imem_pc), .imem_instr(imem_instr), .imem_inv(imem_inv),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .fault(fault), .fault_pc(fault_pc), .state(state)
   );

   always #5 clk = ~clk;

   // Instruction memory: valid for aligned addresses below 0x1000.
   function automatic logic mem_inv(input logic [63:0] a);
      return (a[1:0] != 2'b00) || (a >= 64'h1000);
   endfunction

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h0:   return 32'h00550533;
         64'h4:   return 32'h40b50533;
         64'h8:   return 32'h00c50533;
         64'hC:   return 32'h00d50533;
         default: return {a[23:0], 8'h13} ^ 32'h5A00_0000;
      endcase
   endfunction

   always_comb begin
      imem_inv   = mem_inv(imem_pc);
      imem_instr = imem_inv ? 32'hxxxx_xxxx : mem_word(imem_pc);
   end

   // Reference model: PC, mode (0 idle, 1 run, 2 fault), fault info, FIFO queue.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      mq[$];
   logic [63:0] m_pc = '0;
   int          m_st = 0;
   logic        m_fault = 1'b0;
   logic [63:0] m_fault_pc = '0;

   // Apply one clock edge to the model using the current inputs, then let the DUT take it too.
   task automatic tick();
      int     sz;
      bit     popped;
      entry_t e;
      sz     = mq.size();
      popped = (sz > 0) && out_ready;
      if (reset) begin
         mq.delete();
         m_pc = RESET_PC; m_st = 0; m_fault = 1'b0; m_fault_pc = '0;
      end else if (redirect_valid) begin
         mq.delete();
         m_pc = redirect_pc; m_st = 1; m_fault = 1'b0;
      end else begin
         if (popped) void'(mq.pop_front());
         if (m_st == 0) begin
            if (start) m_st = 1;
         end else if (m_st == 1) begin
            if (mem_inv(m_pc)) begin
               m_fault = 1'b1; m_fault_pc = m_pc; m_st = 2;
            end else if (sz < DEPTH || popped) begin
               e.pc = m_pc; e.instr = mem_word(m_pc);
               mq.push_back(e);
               m_pc = m_pc + 64'd4;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [227:0] dut_vec();
      return {out_valid, out_pc, out_instr, imem_pc, fault, fault_pc, state};
   endfunction

   function automatic logic [227:0] model_vec();
      logic        v;
      logic [63:0] p;
      logic [31:0] i;
      v = mq.size() != 0;
      p = v ? mq[0].pc : 64'h0;
      i = v ? mq[0].instr : 32'h0;
      return {v, p, i, m_pc, m_fault, m_fault_pc, 2'(m_st)};
   endfunction

   task automatic idle_inputs();
      reset = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL reset_vec: got %h want %h", dut_vec(), model_vec());
      end
      checks++;
      if ({out_valid, out_pc, out_instr, fault, fault_pc} !== '0) begin
         errors++; $display("FAIL reset_outputs: valid=%b pc=%h instr=%h fault=%b fpc=%h want all zero",
                             out_valid, out_pc, out_instr, fault, fault_pc);
      end
      checks++;
      if (imem_pc !== RESET_PC || state !== 2'b00) begin
         errors++; $display("FAIL reset_pc_state: pc=%h state=%b want %h 00", imem_pc, state, RESET_PC);
      end
      checks++;
   endtask

   task automatic test_linear();
      logic [31:0] words [4] = '{32'h00550533, 32'h40b50533, 32'h00c50533, 32'h00d50533};
      do_reset();
      start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL linear_latency: out_valid=%b want 0 one cycle after start", out_valid);
      end
      checks++;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== words[k]) begin
            errors++; $display("FAIL linear_%0d: valid=%b pc=%h instr=%h want 1 %h %h",
                                k, out_valid, out_pc, out_instr, 64'(4 * k), words[k]);
         end
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL linear_vec_%0d: got %h want %h", k, dut_vec(), model_vec());
         end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      if (imem_pc !== 64'h8 || out_pc !== 64'h0 || out_instr !== 32'h00550533 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_hold: pc=%h head=%h instr=%h valid=%b want 8 0 00550533 1",
                             imem_pc, out_pc, out_instr, out_valid);
      end
      checks++;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * k)) begin
            errors++; $display("FAIL bp_drain_%0d: valid=%b pc=%h want 1 %h", k, out_valid, out_pc, 64'(4 * k));
         end
         checks++;
         tick();
      end
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL bp_vec: got %h want %h", dut_vec(), model_vec());
      end
      checks++;
   endtask

   task automatic test_redirect();
      do_reset();
      start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (out_pc !== 64'h4) begin
         errors++; $display("FAIL redir_setup: head=%h want 4", out_pc);
      end
      checks++;
      redirect_valid = 1'b1; redirect_pc = 64'h18;
      tick();
      redirect_valid = 1'b0;
      if (out_valid !== 1'b0 || imem_pc !== 64'h18) begin
         errors++; $display("FAIL redir_flush: valid=%b pc=%h want 0 18", out_valid, imem_pc);
      end
      checks++;
      tick();
      if (out_valid !== 1'b1 || out_pc !== 64'h18 || out_instr !== mem_word(64'h18)) begin
         errors++; $display("FAIL redir_first: valid=%b pc=%h instr=%h want 1 18 %h",
                             out_valid, out_pc, out_instr, mem_word(64'h18));
      end
      checks++;
   endtask

   task automatic test_fault();
      do_reset();
      out_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'hFF8;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      if (fault !== 1'b1 || fault_pc !== 64'h1000 || state !== 2'b10 || imem_pc !== 64'h1000) begin
         errors++; $display("FAIL fault_set: fault=%b fpc=%h state=%b pc=%h want 1 1000 10 1000",
                             fault, fault_pc, state, imem_pc);
      end
      checks++;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (out_valid !== 1'b1 || out_pc !== 64'hFF8 + 64'(4 * k)) begin
            errors++; $display("FAIL fault_drain_%0d: valid=%b pc=%h want 1 %h",
                                k, out_valid, out_pc, 64'hFF8 + 64'(4 * k));
         end
         checks++;
         tick();
      end
      if (out_valid !== 1'b0 || state !== 2'b10) begin
         errors++; $display("FAIL fault_empty: valid=%b state=%b want 0 10", out_valid, state);
      end
      checks++;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (state !== 2'b10 || out_valid !== 1'b0) begin
         errors++; $display("FAIL fault_start_ignored: state=%b valid=%b want 10 0", state, out_valid);
      end
      checks++;
      redirect_valid = 1'b1; redirect_pc = 64'h0;
      tick();
      redirect_valid = 1'b0;
      if (fault !== 1'b0 || state !== 2'b01) begin
         errors++; $display("FAIL fault_clear: fault=%b state=%b want 0 01", fault, state);
      end
      checks++;
      tick();
      if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h00550533) begin
         errors++; $display("FAIL fault_resume: valid=%b pc=%h instr=%h want 1 0 00550533",
                             out_valid, out_pc, out_instr);
      end
      checks++;
   endtask

   task automatic test_misaligned();
      do_reset();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 64'h6;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      if (fault !== 1'b1 || fault_pc !== 64'h6 || out_valid !== 1'b0 || out_instr !== 32'h0) begin
         errors++; $display("FAIL misaligned: fault=%b fpc=%h valid=%b instr=%h want 1 6 0 0",
                             fault, fault_pc, out_valid, out_instr);
      end
      checks++;
   endtask

   task automatic test_reset_midrun();
      do_reset();
      start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      if (out_valid !== 1'b1 || state !== 2'b01) begin
         errors++; $display("FAIL midrun_setup: valid=%b state=%b want 1 01", out_valid, state);
      end
      checks++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if (out_valid !== 1'b0 || imem_pc !== RESET_PC || state !== 2'b00 || fault !== 1'b0) begin
         errors++; $display("FAIL midrun_reset: valid=%b pc=%h state=%b fault=%b want 0 %h 00 0",
                             out_valid, imem_pc, state, fault, RESET_PC);
      end
      checks++;
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset          = ($urandom_range(0, 199) == 0);
         start          = ($urandom_range(0, 7) == 0);
         out_ready      = ($urandom_range(0, 1) == 1);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 64'($urandom_range(0, 1031)) * 64'd4;
         if ($urandom_range(0, 5) == 0) redirect_pc = redirect_pc + 64'($urandom_range(1, 3));
         tick();
         if (dut_vec() !== model_vec()) begin
            errors++;
            if (bad < 10) $display("FAIL random_cyc%0d: got %h want %h", c, dut_vec(), model_vec());
            bad++;
         end
         checks++;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_linear();
      test_backpressure();
      test_redirect();
      test_fault();
      test_misaligned();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
